slave_in_port: RTL
==================

SLAVE_IN_PORT -- requirements
Module: slave_in_port

Interface
REQ-001 Parameter ADDR_LEN, default 12, number of address bits per frame.
REQ-002 Parameter DATA_LEN, default 8, number of data bits per write frame.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-005 master_valid  input  1  master drives a frame; held high for every bit of the frame.
REQ-006 write_en  input  1  frame is a write; qualified by master_valid.
REQ-007 read_en  input  1  frame is a read; qualified by master_valid.
REQ-008 rx_address  input  1  serial address bit, LSB first.
REQ-009 rx_data  input  1  serial write-data bit, LSB first; ignored for reads.
REQ-010 slave_ready  output  1  slave can accept a new frame.
REQ-011 core_addr  output  ADDR_LEN  deserialised address.
REQ-012 core_wdata  output  DATA_LEN  deserialised write data.
REQ-013 core_write  output  1  write request to slave core; held until core_ack.
REQ-014 core_read  output  1  read request to slave core; held until core_ack.
REQ-015 core_ack  input  1  slave core has consumed the request.
REQ-016 rx_error  output  1  one-cycle pulse on malformed or aborted frame.

Function
REQ-017 States SHALL be IDLE, RECEIVE, WAIT_CORE.
REQ-018 IDLE: slave_ready=1; handshake cycle T0 is any cycle with master_valid=1, slave_ready=1 and exactly one of write_en/read_en high.
REQ-019 At T0 the block SHALL sample rx_address/rx_data as bit 0, latch mode (write/read), set count=1, drop slave_ready, enter RECEIVE.
REQ-020 Frame length N SHALL be max(ADDR_LEN, DATA_LEN) for writes and ADDR_LEN for reads; bit k sampled at T0+k.
REQ-021 Address bits beyond ADDR_LEN-1 and data bits beyond DATA_LEN-1 SHALL not be shifted in; reads SHALL leave core_wdata unchanged.
REQ-022 After bit N-1 is sampled (T0+N-1), core_write or core_read SHALL assert at T0+N with core_addr/core_wdata stable; state WAIT_CORE.
REQ-023 WAIT_CORE: request and core_addr/core_wdata held, slave_ready=0; on core_ack=1 request deasserts next cycle and state returns to IDLE (slave_ready=1 that same next cycle).
REQ-024 core_ack outside WAIT_CORE SHALL be ignored.
REQ-025 master_valid=0 during RECEIVE before bit N-1: frame discarded, no core request, rx_error pulses next cycle, return to IDLE.
REQ-026 master_valid=1 in IDLE with both or neither enable high: no handshake, state stays IDLE, rx_error pulses next cycle (once per offending cycle).
REQ-027 write_en/read_en changing during RECEIVE SHALL be ignored; latched mode governs the frame.
REQ-028 Bit counter width SHALL be clog2(max(ADDR_LEN, DATA_LEN))+1; counter wraps to 0 on every return to IDLE.
REQ-029 core_write and core_read SHALL never be high simultaneously.

Reset
REQ-030 On reset: state=IDLE, count=0, slave_ready=1, core_write=0, core_read=0, rx_error=0, core_addr=0, core_wdata=0.
REQ-031 Reset asserted in RECEIVE or WAIT_CORE SHALL abort the frame with no rx_error and no core request after the reset edge.

Structure
REQ-032 State encoding and mode constants (INACTIVE=2'b00, WRITE=2'b10, READ=2'b11) SHALL live in shared package bus_pkg, also used by master ports.
REQ-033 One sub-module, serial_deserializer (parameter WIDTH, shift-enable, LSB-first), SHALL be instantiated twice: address and data.

Verification
REQ-034 Write addr 0xA5C, data 0x3B, core_ack at T0+13 -> core_write high T0+12..T0+13, core_addr=0xA5C, core_wdata=0x3B, slave_ready=1 at T0+14.
REQ-035 Read addr 0x123, core_ack same cycle as request -> core_read high exactly at T0+12, core_addr=0x123, core_wdata unchanged.
REQ-036 master_valid drops after 5 bits -> rx_error pulse 1 cycle, no core_write/core_read, slave_ready=1 next cycle.
REQ-037 write_en=read_en=1 with master_valid=1 for 2 cycles -> 2 rx_error pulses, slave_ready stays 1, no frame started.
REQ-038 reset at T0+6 of a write -> all outputs at reset values next cycle; following write addr 0x001 data 0xFF received correctly.
REQ-039 DATA_LEN=16, ADDR_LEN=12 write data 0xBEEF addr 0x7FF -> core_write at T0+16 with both fields correct.

Source files
------------

// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared serial bus state and mode encodings
package bus_pkg;

    typedef logic [1:0] state_t;
    typedef logic [1:0] mode_t;

    localparam state_t IDLE      = 2'd0;
    localparam state_t RECEIVE   = 2'd1;
    localparam state_t WAIT_CORE = 2'd2;

    localparam mode_t INACTIVE = 2'b00;
    localparam mode_t WRITE    = 2'b10;
    localparam mode_t READ     = 2'b11;

    function automatic int max_len(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/serial_deserializer.sv
// rtl/serial_deserializer.sv - LSB-first shift register, one bit per enabled cycle
module serial_deserializer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             shift_en_i,
    input  logic             bit_i,
    output logic [WIDTH-1:0] data_o
);

    logic [WIDTH-1:0] shreg_q, shreg_d;

    // New bits enter at the MSB, so after exactly WIDTH shifts bit 0 sits at position 0.
    always_comb begin
        shreg_d = shreg_q;
        if (shift_en_i) begin
            shreg_d = (shreg_q >> 1) | (WIDTH'(bit_i) << (WIDTH - 1));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shreg_q <= '0;
        end else begin
            shreg_q <= shreg_d;
        end
    end

    assign data_o = shreg_q;

endmodule

// File: rtl/slave_in_port.sv
// rtl/slave_in_port.sv - serial frame receiver presenting address/data requests to a slave core
module slave_in_port
    import bus_pkg::*;
#(
    parameter int ADDR_LEN = 12,
    parameter int DATA_LEN = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                master_valid,
    input  logic                write_en,
    input  logic                read_en,
    input  logic                rx_address,
    input  logic                rx_data,
    output logic                slave_ready,
    output logic [ADDR_LEN-1:0] core_addr,
    output logic [DATA_LEN-1:0] core_wdata,
    output logic                core_write,
    output logic                core_read,
    input  logic                core_ack,
    output logic                rx_error
);

    localparam int MAX_LEN = max_len(ADDR_LEN, DATA_LEN);
    localparam int CNT_W   = $clog2(MAX_LEN) + 1;

    localparam logic [CNT_W-1:0] WR_LAST  = CNT_W'(MAX_LEN - 1);
    localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(ADDR_LEN - 1);
    localparam logic [CNT_W-1:0] ADDR_LIM = CNT_W'(ADDR_LEN);
    localparam logic [CNT_W-1:0] DATA_LIM = CNT_W'(DATA_LEN);

    state_t           state_q, state_d;
    mode_t            mode_q, mode_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             core_write_q, core_write_d;
    logic             core_read_q, core_read_d;
    logic             rx_error_q, rx_error_d;

    logic             sample;
    logic             sample_write;
    logic [CNT_W-1:0] bit_idx;
    logic             addr_shift;
    logic             data_shift;

    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        count_d      = count_q;
        core_write_d = core_write_q;
        core_read_d  = core_read_q;
        rx_error_d   = 1'b0;
        sample       = 1'b0;
        sample_write = 1'b0;
        bit_idx      = count_q;

        case (state_q)
            IDLE: begin
                if (master_valid) begin
                    if (write_en ^ read_en) begin
                        sample       = 1'b1;
                        sample_write = write_en;
                        bit_idx      = '0;
                        mode_d       = write_en ? WRITE : READ;
                        // A one-bit frame completes on the handshake cycle itself.
                        if ((write_en ? WR_LAST : RD_LAST) == '0) begin
                            state_d      = WAIT_CORE;
                            core_write_d = write_en;
                            core_read_d  = read_en;
                            count_d      = '0;
                        end else begin
                            state_d = RECEIVE;
                            count_d = CNT_W'(1);
                        end
                    end else begin
                        rx_error_d = 1'b1;
                    end
                end
            end
            RECEIVE: begin
                if (!master_valid) begin
                    state_d    = IDLE;
                    mode_d     = INACTIVE;
                    count_d    = '0;
                    rx_error_d = 1'b1;
                end else begin
                    sample       = 1'b1;
                    sample_write = (mode_q == WRITE);
                    if (count_q == ((mode_q == WRITE) ? WR_LAST : RD_LAST)) begin
                        state_d      = WAIT_CORE;
                        core_write_d = (mode_q == WRITE);
                        core_read_d  = (mode_q == READ);
                    end else begin
                        count_d = count_q + CNT_W'(1);
                    end
                end
            end
            WAIT_CORE: begin
                if (core_ack) begin
                    state_d      = IDLE;
                    mode_d       = INACTIVE;
                    count_d      = '0;
                    core_write_d = 1'b0;
                    core_read_d  = 1'b0;
                end
            end
            default: begin
                state_d      = IDLE;
                mode_d       = INACTIVE;
                count_d      = '0;
                core_write_d = 1'b0;
                core_read_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            mode_q       <= INACTIVE;
            count_q      <= '0;
            core_write_q <= 1'b0;
            core_read_q  <= 1'b0;
            rx_error_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            count_q      <= count_d;
            core_write_q <= core_write_d;
            core_read_q  <= core_read_d;
            rx_error_q   <= rx_error_d;
        end
    end

    // Bits past a field's width are dropped so the shorter field keeps its aligned value.
    assign addr_shift = sample && (bit_idx < ADDR_LIM);
    assign data_shift = sample && sample_write && (bit_idx < DATA_LIM);

    serial_deserializer #(.WIDTH(ADDR_LEN)) u_addr_deser (
        .clk        (clk),
        .reset      (reset),
        .shift_en_i (addr_shift),
        .bit_i      (rx_address),
        .data_o     (core_addr)
    );

    serial_deserializer #(.WIDTH(DATA_LEN)) u_data_deser (
        .clk        (clk),
        .reset      (reset),
        .shift_en_i (data_shift),
        .bit_i      (rx_data),
        .data_o     (core_wdata)
    );

    assign slave_ready = (state_q == IDLE);
    assign core_write  = core_write_q;
    assign core_read   = core_read_q;
    assign rx_error    = rx_error_q;

endmodule
